// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings, FSM states and sizing for the multiply/divide unit.
package mdu_pkg;

    // Architectural operand width and number of radix-2 iterations per op.
    localparam int unsigned XLEN = 32;
    localparam int unsigned ITER = XLEN;

    // op field encodings; bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement negate of a WIDTH-bit value.
module mdu_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Negate when enabled, otherwise pass through unchanged.
    always_comb begin
        o_data = i_data;
        if (i_en) begin
            o_data = ~i_data + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide with architectural HI/LO registers.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] WriteData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e               r_state;
    logic [CNT_W-1:0]     r_cnt;
    // Upper half: partial product / remainder. Lower half: multiplier / dividend->quotient.
    logic [2*WIDTH-1:0]   r_acc;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]     r_opnd;
    logic [WIDTH-1:0]     r_srca;
    logic                 r_is_div;
    logic                 r_div0;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_signed;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_sign_a = w_signed & SrcA[WIDTH-1];
    assign w_sign_b = w_signed & SrcB[WIDTH-1];

    mdu_negate #(.WIDTH(WIDTH)) u_abs_a (
        .i_en   (w_sign_a),
        .i_data (SrcA),
        .o_data (w_abs_a)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_abs_b (
        .i_en   (w_sign_b),
        .i_data (SrcB),
        .o_data (w_abs_b)
    );

    // Shift-add step: conditionally add the multiplicand to the upper half, then shift right.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        if (r_acc[0]) begin
            w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
        end
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    end

    // Restoring step: shift the next dividend bit into the remainder and trial-subtract.
    always_comb begin
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        if (w_div_diff[WIDTH]) begin
            w_div_next = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_div_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
    end

    // r_neg_res is only ever set for signed ops, so MULTU/DIVU pass through untouched.
    mdu_negate #(.WIDTH(2*WIDTH)) u_prod_fix (
        .i_en   (r_neg_res),
        .i_data (r_acc),
        .o_data (w_prod_fix)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_quo_fix (
        .i_en   (r_neg_res),
        .i_data (r_acc[WIDTH-1:0]),
        .o_data (w_quo_fix)
    );

    mdu_negate #(.WIDTH(WIDTH)) u_rem_fix (
        .i_en   (r_neg_rem),
        .i_data (r_acc[2*WIDTH-1:WIDTH]),
        .o_data (w_rem_fix)
    );

    // Control FSM, iteration datapath and HI/LO with registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_srca    <= '0;
            r_is_div  <= 1'b0;
            r_div0    <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (hi_we) begin
                        r_hi <= WriteData;
                    end
                    if (lo_we) begin
                        r_lo <= WriteData;
                    end
                    if (start) begin
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_cnt     <= CNT_W'(WIDTH - 1);
                        r_is_div  <= op[1];
                        r_srca    <= SrcA;
                        r_div0    <= (SrcB == '0);
                        r_neg_res <= w_sign_a ^ w_sign_b;
                        r_neg_rem <= w_sign_a;
                        if (op[1]) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                            r_opnd <= w_abs_b;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                            r_opnd <= w_abs_a;
                        end
                    end
                end
                RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_div0) begin
                        // Divide by zero still runs the full latency; result is fixed.
                        r_hi <= r_srca;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomized checks of mult_div_unit against an arithmetic model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] WriteData = '0;
    logic        busy;
    logic        done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench view of the architectural HI/LO contents.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .WriteData (WriteData),
        .busy      (busy),
        .done      (done),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // MIPS semantics computed with plain wide arithmetic; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              q;
        int              r;
        case (o)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            2'b01: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                return up;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and follow it to completion. Returns in the done cycle.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit glitch, input bit with_hi_we);
        logic [63:0] exp;
        int          cyc;
        int          nbusy;
        exp   = model(o, a, b);
        start = 1'b1;
        op    = o;
        SrcA  = a;
        SrcB  = b;
        if (with_hi_we) begin
            hi_we     = 1'b1;
            WriteData = 32'h1234;
        end
        tick();
        start = 1'b0;
        hi_we = 1'b0;
        check({name, ".busy_on"}, 64'(busy), 64'd1);
        if (with_hi_we) begin
            m_hi = 32'h1234;
            check({name, ".hi_we_start"}, 64'(Hi), 64'(m_hi));
        end
        cyc   = 0;
        nbusy = 1;
        while (!done && cyc < 100) begin
            start = 1'b0;
            hi_we = 1'b0;
            lo_we = 1'b0;
            if (glitch && (cyc == 5 || cyc == 20)) begin
                start = 1'b1;
                op    = 2'($urandom);
                SrcA  = $urandom;
                SrcB  = $urandom;
            end
            if (glitch && cyc == 8) begin
                hi_we     = 1'b1;
                lo_we     = 1'b1;
                WriteData = $urandom;
            end
            tick();
            cyc++;
            if (busy) nbusy++;
            if (cyc == 16) begin
                check({name, ".hilo_stable"}, {Hi, Lo}, {m_hi, m_lo});
            end
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check({name, ".latency"}, 64'(cyc), 64'd33);
        check({name, ".busy_cycles"}, 64'(nbusy), 64'd33);
        check({name, ".result"}, {Hi, Lo}, exp);
        {m_hi, m_lo} = exp;
    endtask

    initial begin
        int          dones;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;

        // Reset state.
        tick();
        tick();
        reset = 1'b0;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hilo", {Hi, Lo}, 64'd0);

        // mthi / mtlo in IDLE.
        hi_we     = 1'b1;
        WriteData = 32'h1234;
        tick();
        hi_we = 1'b0;
        m_hi  = 32'h1234;
        check("mthi.idle", 64'(Hi), 64'(m_hi));
        lo_we     = 1'b1;
        WriteData = 32'h5678;
        tick();
        lo_we = 1'b0;
        m_lo  = 32'h5678;
        check("mtlo.idle", {Hi, Lo}, {m_hi, m_lo});

        // Directed ops; consecutive calls also exercise start issued in the done cycle.
        run_op("multu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_ff.const", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_m3x5", 2'b00, -32'sd3, 32'd5, 1'b0, 1'b0);
        check("mult_m3x5.const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div_m7_2", 2'b10, -32'sd7, 32'd2, 1'b0, 1'b0);
        check("div_m7_2.const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        check("divu_100_7.const", {Hi, Lo}, {32'd2, 32'd14});
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_ovf.const", {Hi, Lo}, {32'd0, 32'h8000_0000});
        run_op("divu_5_0", 2'b11, 32'd5, 32'd0, 1'b0, 1'b0);
        check("divu_5_0.const", {Hi, Lo}, {32'd5, 32'hFFFF_FFFF});
        run_op("div_m9_0", 2'b10, -32'sd9, 32'd0, 1'b0, 1'b0);
        check("div_m9_0.const", {Hi, Lo}, {32'hFFFF_FFF7, 32'hFFFF_FFFF});

        // Ignored start and mthi/mtlo while busy.
        run_op("glitch_mult", 2'b00, 32'h1234_5678, -32'sd99, 1'b1, 1'b0);
        run_op("glitch_div", 2'b10, -32'sd1000, 32'd33, 1'b1, 1'b0);

        // mthi together with start, result later overwrites Hi.
        tick();
        run_op("hi_we_start", 2'b11, 32'd77, 32'd10, 1'b0, 1'b1);
        check("hi_we_start.over", 64'(Hi), 64'd7);

        // Reset in the middle of RUN.
        tick();
        start = 1'b1;
        op    = 2'b01;
        SrcA  = 32'hDEAD_BEEF;
        SrcB  = 32'h0000_1001;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (done) dones++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset.busy", 64'(busy), 64'd0);
        check("midreset.hilo", {Hi, Lo}, 64'd0);
        check("midreset.done", 64'(done), 64'd0);
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dones++;
        end
        check("midreset.no_done", 64'(dones), 64'd0);
        run_op("after_reset", 2'b00, -32'sd12345, -32'sd678, 1'b0, 1'b0);

        // Randomized ops with biased corner operands.
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: rb = -32'($urandom_range(1, 20));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) tick();
            run_op($sformatf("rand%0d", n), ro, ra, rb, ($urandom_range(0, 4) == 0), 1'b0);
        end

        tick();
        check("final.done_low", 64'(done), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
